// File: rtl/ctle_fz_adapt.sv
// Sign-sign CTLE zero-frequency adaptation: slices the CTLE output and steps the v_fz DAC code.
// Optional macro CTLE_FZ_FORCE_EN adds force_en/force_code for direct code override.
module ctle_fz_adapt #(
    parameter int unsigned CODE_W     = 6,
    parameter int unsigned RESET_CODE = 32,
    parameter real         VFZ_MIN    = 0.4,
    parameter real         VFZ_LSB    = 0.0125,
    parameter real         TARGET     = 0.05,
    parameter int unsigned WIN        = 64,
    parameter int unsigned HYST       = 4,
    parameter int unsigned SETTLE     = 16,
    parameter int unsigned LOCK_CNT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
`ifdef CTLE_FZ_FORCE_EN
    input  logic              force_en,
    input  logic [CODE_W-1:0] force_code,
`endif
    input  real               voutp,
    input  real               voutn,
    output logic              data_out,
    output logic [CODE_W-1:0] fz_code,
    output real               v_fz,
    output logic              locked,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(WIN + 1);
    localparam int unsigned SET_W = $clog2(SETTLE + 1);
    localparam int unsigned LCK_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  WIN_LAST    = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0]  HI_TH       = CNT_W'(WIN / 2 + HYST);
    localparam logic [CNT_W-1:0]  LO_TH       = CNT_W'(WIN / 2 - HYST);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [LCK_W-1:0]  LOCK_FULL   = LCK_W'(LOCK_CNT);
    localparam logic [CODE_W-1:0] CODE_MAX    = '1;
    localparam logic [CODE_W-1:0] CODE_RST    = CODE_W'(RESET_CODE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_UPDATE
    } state_t;

    state_t            r_state, w_state_n;
    logic [CODE_W-1:0] r_code, w_code_n;
    logic              r_locked, w_locked_n;
    logic              r_data;
    logic [SET_W-1:0]  r_settle_cnt, w_settle_n;
    logic [CNT_W-1:0]  r_sample_cnt, w_sample_n;
    logic [CNT_W-1:0]  r_hi_cnt, w_hi_n;
    logic [LCK_W-1:0]  r_lock_cnt, w_lock_n;
    logic [LCK_W-1:0]  w_lock_inc;

    real  w_diff;
    logic w_hi;
    logic w_dec;
    logic w_inc;

    always_comb begin
        w_diff = voutp - voutn;
        w_hi   = (w_diff > TARGET) || (w_diff < -TARGET);
    end

    assign w_dec      = (r_hi_cnt > HI_TH) && (r_code != '0);
    assign w_inc      = (r_hi_cnt < LO_TH) && (r_code != CODE_MAX);
    assign w_lock_inc = (r_lock_cnt == LOCK_FULL) ? r_lock_cnt : r_lock_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_code       <= CODE_RST;
            r_locked     <= 1'b0;
            r_data       <= 1'b0;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_hi_cnt     <= '0;
            r_lock_cnt   <= '0;
        end else begin
            r_state      <= w_state_n;
            r_code       <= w_code_n;
            r_locked     <= w_locked_n;
            r_data       <= (w_diff > 0.0);
            r_settle_cnt <= w_settle_n;
            r_sample_cnt <= w_sample_n;
            r_hi_cnt     <= w_hi_n;
            r_lock_cnt   <= w_lock_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_code_n   = r_code;
        w_locked_n = r_locked;
        w_settle_n = r_settle_cnt;
        w_sample_n = r_sample_cnt;
        w_hi_n     = r_hi_cnt;
        w_lock_n   = r_lock_cnt;

        if (!en) begin
            w_state_n  = ST_IDLE;
            w_settle_n = '0;
            w_sample_n = '0;
            w_hi_n     = '0;
            w_lock_n   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_n  = ST_SETTLE;
                    w_settle_n = '0;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        w_state_n  = ST_ACCUM;
                        w_settle_n = '0;
                        w_sample_n = '0;
                        w_hi_n     = '0;
                    end else begin
                        w_settle_n = r_settle_cnt + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    w_sample_n = r_sample_cnt + 1'b1;
                    if (w_hi)
                        w_hi_n = r_hi_cnt + 1'b1;
                    if (r_sample_cnt == WIN_LAST)
                        w_state_n = ST_UPDATE;
                end
                ST_UPDATE: begin
                    w_sample_n = '0;
                    w_hi_n     = '0;
                    w_settle_n = '0;
                    // A step blocked at a rail falls through to the hold path so lock can still build.
                    if (w_dec || w_inc) begin
                        w_code_n   = w_dec ? r_code - 1'b1 : r_code + 1'b1;
                        w_state_n  = ST_SETTLE;
                        w_lock_n   = '0;
                        w_locked_n = 1'b0;
                    end else begin
                        w_state_n  = ST_ACCUM;
                        w_lock_n   = w_lock_inc;
                        w_locked_n = r_locked || (w_lock_inc == LOCK_FULL);
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end

`ifdef CTLE_FZ_FORCE_EN
        if (force_en) begin
            w_state_n  = ST_IDLE;
            w_code_n   = force_code;
            w_locked_n = 1'b0;
            w_settle_n = '0;
            w_sample_n = '0;
            w_hi_n     = '0;
            w_lock_n   = '0;
        end
`endif
    end

    assign data_out = r_data;
    assign fz_code  = r_code;
    assign locked   = r_locked;
    assign busy     = (r_state != ST_IDLE);

    always_comb v_fz = VFZ_MIN + real'(r_code) * VFZ_LSB;

endmodule

// File: tb/tb_ctle_fz_adapt.sv
// Directed self-checking bench for ctle_fz_adapt (define CTLE_FZ_FORCE_EN to exercise the force path).
module tb_ctle_fz_adapt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    real        voutp;
    real        voutn;
    logic       data_out;
    logic [5:0] fz_code;
    real        v_fz;
    logic       locked;
    logic       busy;
`ifdef CTLE_FZ_FORCE_EN
    logic       force_en;
    logic [5:0] force_code;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int mode     = 0;
    logic ph     = 1'b0;
    int vmax_u   = 0;
    int vmin_u   = 100000;

    ctle_fz_adapt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
`ifdef CTLE_FZ_FORCE_EN
        .force_en   (force_en),
        .force_code (force_code),
`endif
        .voutp      (voutp),
        .voutn      (voutn),
        .data_out   (data_out),
        .fz_code    (fz_code),
        .v_fz       (v_fz),
        .locked     (locked),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int unsigned vu(input real v);
        return $rtoi(v * 10000.0 + 0.5);
    endfunction

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_diff(input real d);
        voutp = 0.9 + d / 2.0;
        voutn = 0.9 - d / 2.0;
    endtask

    task automatic wait_change(input int budget, output int n);
        logic [5:0] prev;
        prev = fz_code;
        n = 0;
        while (fz_code == prev && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_code(input logic [5:0] target, input int budget);
        int n;
        n = 0;
        while (fz_code != target && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_locked(input int budget, output int n);
        n = 0;
        while (!locked && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick(1);
    endtask

    // Differential stimulus generator; mode 0 leaves voutp/voutn to the main sequence.
    initial forever begin
        @(posedge clk);
        #2;
        ph = ~ph;
        case (mode)
            1: set_diff(ph ? 0.2 : -0.2);
            2: set_diff(ph ? 0.01 : -0.01);
            3: set_diff(ph ? 0.2 : -0.01);
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (vu(v_fz) > vmax_u) vmax_u = vu(v_fz);
            if (vu(v_fz) < vmin_u) vmin_u = vu(v_fz);
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        en    = 1'b0;
        voutp = 0.9;
        voutn = 0.9;
`ifdef CTLE_FZ_FORCE_EN
        force_en   = 1'b0;
        force_code = '0;
`endif
        #23 rst_n = 1'b1;
        tick(1);

        check("rst_code", fz_code, 32);
        check("rst_vfz", vu(v_fz), 8000);
        check("rst_locked", locked, 0);
        check("rst_busy", busy, 0);
        check("rst_data", data_out, 0);

        voutp = 0.95; voutn = 0.89;
        #1 check("slice_latency", data_out, 0);
        tick(1);
        check("slice_pos", data_out, 1);
        voutp = 0.89; voutn = 0.95;
        #1 check("slice_hold", data_out, 1);
        tick(1);
        check("slice_neg", data_out, 0);
        voutp = 0.95; voutn = 0.89;
        tick(1);
        check("slice_pos2", data_out, 1);
        voutp = 0.9; voutn = 0.9;
        tick(1);
        check("slice_eq", data_out, 0);
        check("slice_idle_busy", busy, 0);

        // Large amplitude: code walks down to the bottom rail, then locks there.
        mode = 1;
        en   = 1'b1;
        tick(1);
        check("large_busy", busy, 1);
        wait_change(200, n);
        check("large_first", fz_code, 31);
        wait_change(200, n);
        check("large_period", n, 81);
        check("large_second", fz_code, 30);
        check("large_unlocked", locked, 0);
        wait_code(6'd0, 40 * 81);
        check("large_rail", fz_code, 0);
        check("large_vmin", vu(v_fz), 4000);
        check("large_not_yet", locked, 0);
        wait_locked(400, n);
        check("large_lock_time", n, 276);
        check("large_locked", locked, 1);
        check("large_code_held", fz_code, 0);
        check("large_vfz_floor", vmin_u, 4000);

        // Small amplitude: code climbs to the top rail and stays.
        mode = 2;
        wait_change(200, n);
        check("small_first", fz_code, 1);
        check("small_unlocked", locked, 0);
        wait_code(6'd63, 64 * 81);
        check("small_rail", fz_code, 63);
        check("small_vmax", vu(v_fz), 11875);
        tick(400);
        check("small_stay", fz_code, 63);
        check("small_locked", locked, 1);
        check("small_vfz_ceiling", vmax_u, 11875);

        // Hold band: exactly half the samples exceed the target.
        en = 1'b0;
        do_reset();
        check("hold_rst_code", fz_code, 32);
        mode = 3;
        en   = 1'b1;
        wait_locked(600, n);
        check("hold_lock_time", n, 277);
        check("hold_locked", locked, 1);
        check("hold_code", fz_code, 32);
        mode = 1;
        wait_change(70, n);
        check("hold_exit_code", fz_code, 31);
        check("hold_exit_unlock", locked, 0);

        // Abort mid-window by dropping en, then resume from SETTLE.
        en = 1'b0;
        do_reset();
        en = 1'b1;
        tick(1);
        tick(16);
        tick(39);
        check("abort_busy_pre", busy, 1);
        en = 1'b0;
        tick(1);
        check("abort_busy", busy, 0);
        check("abort_code", fz_code, 32);
        tick(3);
        check("abort_idle", busy, 0);
        en = 1'b1;
        wait_change(200, n);
        check("resume_time", n, 82);
        check("resume_code", fz_code, 31);

        tick(40);
        check("arst_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_code", fz_code, 32);
        check("arst_busy", busy, 0);
        check("arst_vfz", vu(v_fz), 8000);
        #1 rst_n = 1'b1;
        tick(1);

`ifdef CTLE_FZ_FORCE_EN
        force_code = 6'd10;
        force_en   = 1'b1;
        tick(1);
        check("force_code", fz_code, 10);
        check("force_vfz", vu(v_fz), 5250);
        check("force_busy", busy, 0);
        check("force_locked", locked, 0);
        tick(3);
        check("force_idle", busy, 0);
        force_en = 1'b0;
        wait_change(200, n);
        check("force_release_time", n, 82);
        check("force_release_code", fz_code, 9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
